// File: rtl/dtc_vote_accum.sv
// Majority-vote accumulator over WINDOW decision-tree predictions (4 classes, ties to lowest index).
// Optional macro DTC_VOTE_CONF_EN adds the out_conf port carrying the winning vote count.
module dtc_vote_accum #(
    parameter int WINDOW = 16,
    localparam int CNT_W = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_class,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_class
`ifdef DTC_VOTE_CONF_EN
    ,
    output logic [CNT_W-1:0] out_conf
`endif
);

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [3:0][CNT_W-1:0]   cnt;
    logic [3:0][CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]        samp;
    logic                    accept;
    logic                    last;
    logic [1:0]              win_class;

    // Strict greater-than scan so the lowest index keeps a tie.
    function automatic logic [1:0] argmax(input logic [3:0][CNT_W-1:0] c);
        logic [1:0] best;
        best = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (c[i] > c[best]) best = 2'(i);
        end
        return best;
    endfunction

    always_comb begin
        cnt_inc           = cnt;
        cnt_inc[in_class] = cnt[in_class] + CNT_W'(1);
        win_class         = argmax(cnt_inc);
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = !clear;
                if (last) state_nxt = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
        if (clear) state_nxt = ACCUM;
    end

    assign accept = in_valid && in_ready;
    assign last   = accept && (samp == CNT_W'(WINDOW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_nxt;
    end

    // Counters and result register; emptied on clear and on the output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            samp      <= '0;
            out_class <= 2'd0;
`ifdef DTC_VOTE_CONF_EN
            out_conf  <= '0;
`endif
        end else if (clear || (out_valid && out_ready)) begin
            cnt       <= '0;
            samp      <= '0;
            out_class <= 2'd0;
`ifdef DTC_VOTE_CONF_EN
            out_conf  <= '0;
`endif
        end else if (accept) begin
            cnt  <= cnt_inc;
            samp <= samp + CNT_W'(1);
            if (last) begin
                out_class <= win_class;
`ifdef DTC_VOTE_CONF_EN
                out_conf  <= cnt_inc[win_class];
`endif
            end
        end
    end

endmodule

// File: tb/tb_dtc_vote_accum.sv
// Self-checking bench for dtc_vote_accum with WINDOW=4: directed table, corner sequences, random vs. model.
module tb_dtc_vote_accum;

    localparam int WINDOW = 4;
    localparam int CNT_W  = $clog2(WINDOW + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_class;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_class;
`ifdef DTC_VOTE_CONF_EN
    logic [CNT_W-1:0] out_conf;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dtc_vote_accum #(.WINDOW(WINDOW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_class  (in_class),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class)
`ifdef DTC_VOTE_CONF_EN
        ,
        .out_conf  (out_conf)
`endif
    );

    typedef struct {
        logic [1:0] c0, c1, c2, c3;
        logic [1:0] exp_class;
        int         exp_conf;
        string      name;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic check_conf(input string nm, input int exp);
`ifdef DTC_VOTE_CONF_EN
        check(nm, 32'(out_conf), exp);
`else
        if (exp < 0) $display("note: %s unused", nm);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c);
        in_valid = 1'b1;
        in_class = c;
        step();
        in_valid = 1'b0;
    endtask

    task automatic run_window(input logic [1:0] c0, c1, c2, c3, input logic [1:0] ec,
                              input int econf, input bit hs, input string nm);
        logic [1:0] cs [4];
        cs[0] = c0; cs[1] = c1; cs[2] = c2; cs[3] = c3;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_class = cs[i];
            #1;
            check({nm, "_in_ready"}, 32'(in_ready), 1);
            step();
            if (i < 3) check({nm, "_early_valid"}, 32'(out_valid), 0);
        end
        in_valid = 1'b0;
        check({nm, "_out_valid"}, 32'(out_valid), 1);
        check({nm, "_out_class"}, 32'(out_class), 32'(ec));
        check_conf({nm, "_out_conf"}, econf);
        if (hs) begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check({nm, "_hs_valid"}, 32'(out_valid), 0);
            check({nm, "_hs_ready"}, 32'(in_ready), 1);
            check({nm, "_hs_class"}, 32'(out_class), 0);
        end
    endtask

    function automatic void majority(input int q[$], output int cls, output int conf);
        int counts [4];
        for (int k = 0; k < 4; k++) counts[k] = 0;
        foreach (q[i]) counts[q[i]] += 1;
        cls = 0;
        for (int k = 1; k < 4; k++) if (counts[k] > counts[cls]) cls = k;
        conf = counts[cls];
    endfunction

    initial begin
        int  q[$];
        bit  m_emit;
        int  m_cls, m_conf;
        bit  iv, ordy, clr;
        logic [1:0] rc;

        vecs[0] = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd1, 2, "basic_1123"};
        vecs[1] = '{2'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2, "tie_0330"};
        vecs[2] = '{2'd2, 2'd1, 2'd1, 2'd2, 2'd1, 2, "tie_2112"};
        vecs[3] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 4, "all_3"};
        vecs[4] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 1, "four_way_tie"};
        vecs[5] = '{2'd3, 2'd2, 2'd2, 2'd2, 2'd2, 3, "maj_2"};

        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_class  = 2'd0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_class", 32'(out_class), 0);
        check_conf("rst_out_conf", 0);
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", 32'(in_ready), 1);

        // Pending result, then reset asserted mid-cycle.
        run_window(2'd1, 2'd1, 2'd2, 2'd3, 2'd1, 2, 1'b0, "pre_reset");
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 0);
        check("async_rst_class", 32'(out_class), 0);
        check_conf("async_rst_conf", 0);
        #2;
        rst_n = 1'b1;
        step();
        check("post_rst_ready", 32'(in_ready), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_no_out", 32'(out_valid), 0);
        end

        for (int i = 0; i < 6; i++)
            run_window(vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].c3,
                       vecs[i].exp_class, vecs[i].exp_conf, 1'b1, vecs[i].name);

        // Backpressure with input pressure held during EMIT.
        run_window(2'd2, 2'd2, 2'd3, 2'd0, 2'd2, 2, 1'b0, "bp");
        in_valid = 1'b1;
        in_class = 2'd2;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 0);
            step();
            check("bp_valid_held", 32'(out_valid), 1);
            check("bp_class_held", 32'(out_class), 2);
            check_conf("bp_conf_held", 2);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 0);
        check("bp_release_ready", 32'(in_ready), 1);
        run_window(2'd0, 2'd0, 2'd1, 2'd3, 2'd0, 2, 1'b1, "bp_next");

        // Flush of a partial window, clear coinciding with an input.
        send(2'd0);
        send(2'd0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_class = 2'd0;
        #1;
        check("clear_in_ready", 32'(in_ready), 0);
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear_valid", 32'(out_valid), 0);
        run_window(2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 4, 1'b1, "post_clear");

        // Reset pulse in the middle of a window.
        send(2'd2);
        send(2'd2);
        send(2'd2);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        check("midrst_valid", 32'(out_valid), 0);
        run_window(2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 3, 1'b1, "post_midrst");

        // Random traffic against a queue-based model.
        m_emit = 1'b0;
        m_cls  = 0;
        m_conf = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            iv   = ($urandom_range(0, 3) != 0);
            rc   = 2'($urandom_range(0, 3));
            ordy = ($urandom_range(0, 1) != 0);
            clr  = ($urandom_range(0, 19) == 0);
            in_valid  = iv;
            in_class  = rc;
            out_ready = ordy;
            clear     = clr;
            #1;
            check("rnd_in_ready", 32'(in_ready), 32'(!m_emit && !clr));
            @(posedge clk);
            if (clr) begin
                q.delete();
                m_emit = 1'b0;
                m_cls  = 0;
                m_conf = 0;
            end else if (m_emit) begin
                if (ordy) begin
                    m_emit = 1'b0;
                    m_cls  = 0;
                    m_conf = 0;
                end
            end else if (iv) begin
                q.push_back(int'(rc));
                if (q.size() == WINDOW) begin
                    majority(q, m_cls, m_conf);
                    m_emit = 1'b1;
                    q.delete();
                end
            end
            #1;
            check("rnd_out_valid", 32'(out_valid), 32'(m_emit));
            check("rnd_out_class", 32'(out_class), 32'(m_cls));
            check_conf("rnd_out_conf", m_conf);
        end
        in_valid  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dtc_vote_accum.md
DTC_VOTE_ACCUM -- requirements
Module: dtc_vote_accum

Interface
REQ-001 SHALL provide parameter WINDOW, default 16: number of predictions per vote window, legal range 2..255.
REQ-002 SHALL derive localparam CNT_W = clog2(WINDOW+1), the width of each per-class counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port clear  input  1  synchronous flush of the partial window and any pending result.
REQ-006 SHALL have port in_valid  input  1  in_class is valid.
REQ-007 SHALL have port in_ready  output  1  block accepts a prediction this cycle.
REQ-008 SHALL have port in_class  input  2  2-bit class from the upstream decision-tree classifier.
REQ-009 SHALL have port out_valid  output  1  window result is valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port out_class  output  2  majority class of the completed window.
REQ-012 SHALL have port out_conf  output  CNT_W  vote count of out_class; present only with DTC_VOTE_CONF_EN.

Function
REQ-013 SHALL implement two states: ACCUM (in_ready=1 unless clear=1, out_valid=0) and EMIT (in_ready=0, out_valid=1).
REQ-014 SHALL, in ACCUM, accept a sample when in_valid&&in_ready and increment cnt[in_class] and the sample counter by 1.
REQ-015 SHALL, on the edge accepting the WINDOW-th sample, register out_class (and out_conf) as the argmax of the counts including that sample, then enter EMIT; out_valid is high the next cycle (1-cycle latency).
REQ-016 SHALL resolve ties to the lowest class index.
REQ-017 SHALL hold out_class/out_conf stable and out_valid high in EMIT until out_valid&&out_ready.
REQ-018 SHALL, on the output handshake, zero all four counters and the sample counter and return to ACCUM; in_ready is high the following cycle.
REQ-019 SHALL ignore in_valid while in EMIT (no count change).
REQ-020 SHALL give clear priority over all other events: drive in_ready low while clear=1, discard any simultaneous input, zero all counters, drop out_valid, enter ACCUM next cycle.
REQ-021 SHALL never overflow a counter; the maximum count is WINDOW, which fits in CNT_W bits.
REQ-022 SHALL keep out_class/out_conf at 0 whenever out_valid=0 after reset or clear.

Reset
REQ-023 SHALL, on rst_n low, asynchronously enter ACCUM with all counters 0, out_valid=0, out_class=0, out_conf=0; in_ready=1 after deassertion.
REQ-024 SHALL discard a partial window or pending result on reset mid-operation, with no output produced.

Configuration
REQ-025 SHALL, with macro DTC_VOTE_CONF_EN defined, include port out_conf carrying the winning count.
REQ-026 SHALL, without DTC_VOTE_CONF_EN, omit port out_conf and its register; all other behaviour is identical.

Verification (WINDOW=4, DTC_VOTE_CONF_EN defined)
REQ-027 SHALL check reset: rst_n low mid-cycle -> out_valid=0, out_class=0, out_conf=0 immediately; in_ready=1 after release.
REQ-028 SHALL check a basic window: back-to-back classes 1,1,2,3 -> out_valid high one cycle after the 4th accept, out_class=1, out_conf=2.
REQ-029 SHALL check a tie: classes 0,3,3,0 -> out_class=0, out_conf=2; classes 2,1,1,2 -> out_class=1.
REQ-030 SHALL check backpressure: out_ready low for 5 cycles with in_valid high and class 2 -> out_valid/out_class held, in_ready=0, counts unchanged; raise out_ready -> next window starts from zero.
REQ-031 SHALL check a flush: accept 0,0, pulse clear together with in_valid (class 0), then send 3,3,3,3 -> out_class=3, out_conf=4.
REQ-032 SHALL check reset mid-window: accept 2,2,2, pulse rst_n, then send 1,0,1,1 -> out_class=1, out_conf=3.
